// File: rtl/csr_cnt_pkg.sv
// Shared types and address map for the cycle/instret counter CSR controller.
package csr_cnt_pkg;

   localparam int CSR_XLEN  = 32;
   localparam int CSR_CNT_W = 64;

   typedef enum logic [1:0] {
      OP_READ  = 2'd0,
      OP_WRITE = 2'd1,
      OP_SET   = 2'd2,
      OP_CLEAR = 2'd3
   } csr_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam logic [11:0] ADDR_CYCLE         = 12'hC00;
   localparam logic [11:0] ADDR_CYCLEH        = 12'hC80;
   localparam logic [11:0] ADDR_INSTRET       = 12'hC02;
   localparam logic [11:0] ADDR_INSTRETH      = 12'hC82;
   localparam logic [11:0] ADDR_MCYCLE        = 12'hB00;
   localparam logic [11:0] ADDR_MCYCLEH       = 12'hB80;
   localparam logic [11:0] ADDR_MINSTRET      = 12'hB02;
   localparam logic [11:0] ADDR_MINSTRETH     = 12'hB82;
   localparam logic [11:0] ADDR_MCOUNTINHIBIT = 12'h320;

   localparam int INH_CY = 0;
   localparam int INH_IR = 2;

   // The whole 0xCxx page is the user read-only counter shadow space.
   function automatic logic is_ro_page(input logic [11:0] addr);
      return addr[11:8] == 4'hC;
   endfunction

endpackage

// File: rtl/csr_counter_ctrl_counter64.sv
// Free-running counter built from two halves; a half write wins over increment.
module csr_counter64 #(
   parameter int HALF_W = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  inc_en,
   input  logic                  wr_lo,
   input  logic                  wr_hi,
   input  logic [HALF_W-1:0]     wdata,
   output logic [2*HALF_W-1:0]   cnt
);

   localparam logic [2*HALF_W-1:0] ONE = {{(2*HALF_W-1){1'b0}}, 1'b1};

   logic [2*HALF_W-1:0] cnt_q, cnt_d;

   // Untouched half holds during a write so the written value reads back exactly.
   always_comb begin
      cnt_d = cnt_q;
      if (wr_lo || wr_hi) begin
         if (wr_lo) cnt_d[HALF_W-1:0]        = wdata;
         if (wr_hi) cnt_d[2*HALF_W-1:HALF_W] = wdata;
      end else if (inc_en) begin
         cnt_d = cnt_q + ONE;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/csr_counter_ctrl.sv
// CSR access point for cycle/instret/mcountinhibit: IDLE -> EXEC -> RESP handshake.
module csr_counter_ctrl
   import csr_cnt_pkg::*;
#(
   parameter int XLEN  = CSR_XLEN,
   parameter int CNT_W = CSR_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [1:0]       req_op,
   input  logic [11:0]      req_addr,
   input  logic [XLEN-1:0]  req_wdata,
   output logic             resp_valid,
   input  logic             resp_ready,
   output logic [XLEN-1:0]  resp_rdata,
   output logic             resp_err,
   input  logic             retire
);

   state_e            state_q, state_d;
   csr_op_e           op_q, op_d;
   logic [11:0]       addr_q, addr_d;
   logic [XLEN-1:0]   wdata_q, wdata_d;
   logic [XLEN-1:0]   rdata_q, rdata_d;
   logic              err_q, err_d;
   logic              inh_cy_q, inh_cy_d;
   logic              inh_ir_q, inh_ir_d;

   logic [CNT_W-1:0]  cyc_cnt, ins_cnt;
   logic [XLEN-1:0]   old_val, new_val;
   logic              sel_cyc, sel_ins, sel_inh, sel_hi, mapped;
   logic              has_write, acc_err, commit;

   // Address decode and read-modify-write of the latched request.
   always_comb begin
      old_val = '0;
      sel_cyc = 1'b0;
      sel_ins = 1'b0;
      sel_inh = 1'b0;
      mapped  = 1'b1;
      sel_hi  = addr_q[7];
      case (addr_q)
         ADDR_CYCLE, ADDR_MCYCLE: begin
            sel_cyc = 1'b1;
            old_val = cyc_cnt[XLEN-1:0];
         end
         ADDR_CYCLEH, ADDR_MCYCLEH: begin
            sel_cyc = 1'b1;
            old_val = cyc_cnt[CNT_W-1:XLEN];
         end
         ADDR_INSTRET, ADDR_MINSTRET: begin
            sel_ins = 1'b1;
            old_val = ins_cnt[XLEN-1:0];
         end
         ADDR_INSTRETH, ADDR_MINSTRETH: begin
            sel_ins = 1'b1;
            old_val = ins_cnt[CNT_W-1:XLEN];
         end
         ADDR_MCOUNTINHIBIT: begin
            sel_inh         = 1'b1;
            old_val[INH_CY] = inh_cy_q;
            old_val[INH_IR] = inh_ir_q;
         end
         default: mapped = 1'b0;
      endcase

      case (op_q)
         OP_WRITE: new_val = wdata_q;
         OP_SET:   new_val = old_val | wdata_q;
         OP_CLEAR: new_val = old_val & ~wdata_q;
         default:  new_val = old_val;
      endcase

      // SET/CLEAR with a zero mask is a pure read, so it is legal on read-only CSRs.
      has_write = (op_q == OP_WRITE) ||
                  ((op_q == OP_SET || op_q == OP_CLEAR) && (wdata_q != '0));
      acc_err   = !mapped || (is_ro_page(addr_q) && has_write);
      commit    = (state_q == EXEC) && has_write && !acc_err;
   end

   always_comb begin
      inh_cy_d = inh_cy_q;
      inh_ir_d = inh_ir_q;
      if (commit && sel_inh) begin
         inh_cy_d = new_val[INH_CY];
         inh_ir_d = new_val[INH_IR];
      end
   end

   csr_counter64 #(.HALF_W(XLEN)) u_cycle (
      .clk    (clk),
      .rst    (rst),
      .inc_en (!inh_cy_q),
      .wr_lo  (commit && sel_cyc && !sel_hi),
      .wr_hi  (commit && sel_cyc && sel_hi),
      .wdata  (new_val),
      .cnt    (cyc_cnt)
   );

   csr_counter64 #(.HALF_W(XLEN)) u_instret (
      .clk    (clk),
      .rst    (rst),
      .inc_en (retire && !inh_ir_q),
      .wr_lo  (commit && sel_ins && !sel_hi),
      .wr_hi  (commit && sel_ins && sel_hi),
      .wdata  (new_val),
      .cnt    (ins_cnt)
   );

   always_comb begin
      state_d   = state_q;
      op_d      = op_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;
      err_d     = err_q;
      req_ready = 1'b0;
      case (state_q)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               op_d    = csr_op_e'(req_op);
               addr_d  = req_addr;
               wdata_d = req_wdata;
               state_d = EXEC;
            end
         end
         EXEC: begin
            rdata_d = acc_err ? '0 : old_val;
            err_d   = acc_err;
            state_d = RESP;
         end
         RESP: begin
            if (resp_ready) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         op_q     <= OP_READ;
         addr_q   <= '0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         err_q    <= 1'b0;
         inh_cy_q <= 1'b0;
         inh_ir_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         addr_q   <= addr_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         err_q    <= err_d;
         inh_cy_q <= inh_cy_d;
         inh_ir_q <= inh_ir_d;
      end
   end

   // Decoded straight from the state flop so an async reset drops it at once.
   assign resp_valid = (state_q == RESP);
   assign resp_rdata = rdata_q;
   assign resp_err   = err_q;

endmodule
